// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: advances, holds or redirects the PC and times the wrong-path flush.
// All outputs registered (one-edge latency from inputs); stall holds pc in RUN only.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_branch_valid,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_pc,
    input  logic [31:0]      i_branch_offset,
    input  logic             i_jump_valid,
    input  logic [31:0]      i_jump_target,
    input  logic             i_halt,
    output logic [31:0]      o_pc,
    output logic             o_pc_valid,
    output logic             o_flush,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_redirect_count
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic             r_pc_valid;
    logic             w_pc_valid_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             r_misaligned;
    logic             w_misaligned_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nxt;

    logic [31:0]      w_branch_tgt;
    logic [31:0]      w_jump_tgt;
    logic [31:0]      w_tgt;
    logic             w_tgt_mis;
    logic             w_redirect;

    assign w_branch_tgt = i_branch_pc + 32'd4 + (i_branch_offset << 2);
    assign w_jump_tgt   = i_jump_target << 2;
    assign w_redirect   = i_jump_valid | (i_branch_valid & i_branch_taken);
    assign w_tgt        = i_jump_valid ? w_jump_tgt : w_branch_tgt;
    // The shifted jump target is always word-aligned, so the jump word address's
    // own low bits are what flag a misaligned jump.
    assign w_tgt_mis    = i_jump_valid ? (|i_jump_target[1:0]) : (|w_branch_tgt[1:0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_pc_valid   <= 1'b0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_cnt        <= '0;
            r_fcnt       <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pc_valid   <= w_pc_valid_nxt;
            r_flush      <= w_flush_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fcnt       <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pc_valid_nxt   = r_pc_valid;
        w_flush_nxt      = r_flush;
        w_misaligned_nxt = r_misaligned;
        w_cnt_nxt        = r_cnt;
        w_fcnt_nxt       = r_fcnt;

        case (r_state)
            S_BOOT: begin
                w_state_nxt    = S_RUN;
                w_pc_valid_nxt = 1'b1;
            end
            S_RUN, S_FLUSH: begin
                if (w_redirect) begin
                    w_state_nxt      = S_FLUSH;
                    w_pc_nxt         = {w_tgt[31:2], 2'b00};
                    w_flush_nxt      = 1'b1;
                    w_fcnt_nxt       = FLUSH_LOAD;
                    w_misaligned_nxt = r_misaligned | w_tgt_mis;
                    w_cnt_nxt        = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
                end else if (i_halt) begin
                    w_state_nxt    = S_HALTED;
                    w_pc_valid_nxt = 1'b0;
                    w_flush_nxt    = 1'b0;
                    w_fcnt_nxt     = 3'd0;
                end else if ((r_state == S_RUN) && i_stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = r_pc + 32'd4;
                    if (r_state == S_FLUSH) begin
                        // Counter value 1 marks the last flush cycle.
                        if (r_fcnt <= 3'd1) begin
                            w_state_nxt = S_RUN;
                            w_flush_nxt = 1'b0;
                            w_fcnt_nxt  = 3'd0;
                        end else begin
                            w_fcnt_nxt = r_fcnt - 3'd1;
                        end
                    end
                end
            end
            S_HALTED: begin
                w_pc_valid_nxt = 1'b0;
                w_flush_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign o_pc             = r_pc;
    assign o_pc_valid       = r_pc_valid;
    assign o_flush          = r_flush;
    assign o_misaligned     = r_misaligned;
    assign o_redirect_count = r_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expected values.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misaligned;
    logic [15:0] redirect_count;

    int n_checks = 0;
    int n_fails  = 0;

    pc_redirect_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_branch_valid   (branch_valid),
        .i_branch_taken   (branch_taken),
        .i_branch_pc      (branch_pc),
        .i_branch_offset  (branch_offset),
        .i_jump_valid     (jump_valid),
        .i_jump_target    (jump_target),
        .i_halt           (halt),
        .o_pc             (pc),
        .o_pc_valid       (pc_valid),
        .o_flush          (flush),
        .o_misaligned     (misaligned),
        .o_redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_taken  = 1'b0;
        branch_pc     = 32'h0;
        branch_offset = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;
        halt          = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst_pc",       pc,                     32'h0);
        check("rst_valid",    32'(pc_valid),          32'h0);
        check("rst_flush",    32'(flush),             32'h0);
        check("rst_mis",      32'(misaligned),        32'h0);
        check("rst_count",    32'(redirect_count),    32'h0);

        // Boot then run up to 0x40, reset mid-run.
        rst = 1'b0;
        check("boot_valid",   32'(pc_valid),          32'h0);
        step();
        check("run0_valid",   32'(pc_valid),          32'h1);
        check("run0_pc",      pc,                     32'h0);
        for (int i = 0; i < 16; i++) step();
        check("run_pc_40",    pc,                     32'h40);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc",    pc,                  32'h0);
        check("async_rst_valid", 32'(pc_valid),       32'h0);
        step();
        rst = 1'b0;
        check("boot2_valid",  32'(pc_valid),          32'h0);
        check("boot2_pc",     pc,                     32'h0);
        step();
        check("boot2_run_pc", pc,                     32'h0);
        check("boot2_run_v",  32'(pc_valid),          32'h1);
        step();
        check("boot2_pc4",    pc,                     32'h4);
        step();
        check("boot2_pc8",    pc,                     32'h8);
        check("boot2_flush",  32'(flush),             32'h0);

        // Taken branch from pc 0x20: target 0x18 + 4 - 8 = 0x14.
        for (int i = 0; i < 6; i++) step();
        check("pre_br_pc",    pc,                     32'h20);
        branch_valid  = 1'b1;
        branch_taken  = 1'b1;
        branch_pc     = 32'h18;
        branch_offset = 32'hFFFF_FFFE;
        step();
        clear_inputs();
        check("br_pc",        pc,                     32'h14);
        check("br_flush1",    32'(flush),             32'h1);
        check("br_count",     32'(redirect_count),    32'h1);
        step();
        check("br_pc18",      pc,                     32'h18);
        check("br_flush2",    32'(flush),             32'h1);
        step();
        check("br_pc1c",      pc,                     32'h1C);
        check("br_flush_end", 32'(flush),             32'h0);

        // Not-taken branch advances normally.
        branch_valid = 1'b1;
        branch_taken = 1'b0;
        branch_pc    = 32'h1C;
        branch_offset = 32'h40;
        step();
        clear_inputs();
        check("nt_pc",        pc,                     32'h20);
        check("nt_flush",     32'(flush),             32'h0);
        check("nt_count",     32'(redirect_count),    32'h1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",  pc,                    32'h20);
        end

        // Redirect overrides stall: 0x20 + 4 + 16 = 0x34.
        branch_valid  = 1'b1;
        branch_taken  = 1'b1;
        branch_pc     = 32'h20;
        branch_offset = 32'h4;
        step();
        clear_inputs();
        check("stbr_pc",      pc,                     32'h34);
        check("stbr_flush",   32'(flush),             32'h1);
        check("stbr_count",   32'(redirect_count),    32'h2);
        stall = 1'b1;
        step();
        check("flush_stall_pc", pc,                   32'h38);
        check("flush_stall_fl", 32'(flush),           32'h1);
        stall = 1'b0;
        step();
        check("post_fl_pc",   pc,                     32'h3C);
        check("post_fl_flush", 32'(flush),            32'h0);

        // Jump and branch collide; jump wins, one redirect counted.
        jump_valid    = 1'b1;
        jump_target   = 32'h100;
        branch_valid  = 1'b1;
        branch_taken  = 1'b1;
        branch_pc     = 32'h3C;
        branch_offset = 32'h10;
        step();
        clear_inputs();
        check("coll_pc",      pc,                     32'h400);
        check("coll_count",   32'(redirect_count),    32'h3);
        check("coll_flush",   32'(flush),             32'h1);
        jump_valid  = 1'b1;
        jump_target = 32'h200;
        step();
        clear_inputs();
        check("b2b_pc",       pc,                     32'h800);
        check("b2b_flush1",   32'(flush),             32'h1);
        check("b2b_count",    32'(redirect_count),    32'h4);
        step();
        check("b2b_pc804",    pc,                     32'h804);
        check("b2b_flush2",   32'(flush),             32'h1);
        step();
        check("b2b_pc808",    pc,                     32'h808);
        check("b2b_flush3",   32'(flush),             32'h0);

        // Misaligned jump word address, then wrap past 0xFFFF_FFFC.
        jump_valid  = 1'b1;
        jump_target = 32'h3FFF_FFFF;
        step();
        clear_inputs();
        check("mis_pc",       pc,                     32'hFFFF_FFFC);
        check("mis_flag",     32'(misaligned),        32'h1);
        check("mis_count",    32'(redirect_count),    32'h5);
        step();
        check("wrap_pc",      pc,                     32'h0);
        step();
        check("wrap_pc4",     pc,                     32'h4);
        check("mis_sticky",   32'(misaligned),        32'h1);

        // Halt at 0x30; later jumps ignored.
        for (int i = 0; i < 11; i++) step();
        check("pre_halt_pc",  pc,                     32'h30);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_pc",      pc,                     32'h30);
        check("halt_valid",   32'(pc_valid),          32'h0);
        check("halt_flush",   32'(flush),             32'h0);
        jump_valid  = 1'b1;
        jump_target = 32'h40;
        step();
        step();
        clear_inputs();
        check("halt_jmp_pc",  pc,                     32'h30);
        check("halt_jmp_cnt", 32'(redirect_count),    32'h5);
        check("halt_jmp_v",   32'(pc_valid),          32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hrst_pc",      pc,                     32'h0);
        check("hrst_mis",     32'(misaligned),        32'h0);
        check("hrst_count",   32'(redirect_count),    32'h0);
        step();
        check("hrst_run_v",   32'(pc_valid),          32'h1);

        // Counter saturation: 70000 consecutive redirects.
        jump_valid  = 1'b1;
        jump_target = 32'h10;
        for (int i = 0; i < 70000; i++) step();
        clear_inputs();
        check("sat_count",    32'(redirect_count),    32'hFFFF);
        check("sat_pc",       pc,                     32'h40);
        check("sat_flush",    32'(flush),             32'h1);
        check("sat_mis",      32'(misaligned),        32'h0);
        step();
        check("sat_pc44",     pc,                     32'h44);
        step();
        check("sat_pc48",     pc,                     32'h48);
        check("sat_flush_end", 32'(flush),            32'h0);
        check("sat_hold",     32'(redirect_count),    32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter for the five-stage pipeline and consumes the EX-stage branch decision (taken flag plus sign-extended jump word address).
- Each cycle it advances, holds, or redirects the fetch PC.
- On a redirect it raises a timed flush to squash wrong-path instructions in IF/ID and ID/EX.
- It keeps a misalignment flag and a taken-redirect performance counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (legal range 1..7).
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  hazard-unit hold request
- branch_valid  in  1  EX stage holds a conditional branch (bne/bgtz/bgez/beq)
- branch_taken  in  1  branch condition result from EX
- branch_pc  in  32  PC of the branch/jump instruction in EX
- branch_offset  in  32  sign-extended 16-bit immediate (word offset)
- jump_valid  in  1  EX stage holds an unconditional jump
- jump_target  in  32  sign-extended 26-bit jump word address
- halt  in  1  halt request from decode
- pc  out  32  current fetch address
- pc_valid  out  1  pc is a real fetch this cycle
- flush  out  1  squash IF/ID and ID/EX contents
- misaligned  out  1  sticky: a redirect target had bits [1:0] != 0
- redirect_count  out  CNT_W  saturating count of redirects taken

Behaviour:
- Reset (asynchronous, any state):
  - pc = RESET_PC, pc_valid = 0, flush = 0, misaligned = 0, redirect_count = 0.
  - state = BOOT, flush counter = 0.
- States:
  - BOOT: one cycle after rst deasserts, pc_valid = 0 and pc held. Then go to RUN with pc_valid = 1 and pc = RESET_PC.
  - RUN: normal fetch.
  - FLUSH: redirect in progress.
  - HALTED: terminal.
- Redirect targets (32-bit, wrap-around, no overflow detection):
  - branch_tgt = branch_pc + 4 + (branch_offset << 2).
  - jump_tgt = jump_target << 2, truncated to 32 bits.
- Priority in RUN and FLUSH, evaluated each clock edge:
  1. jump_valid: pc <= jump_tgt.
  2. branch_valid && branch_taken: pc <= branch_tgt.
  3. halt: go to HALTED.
  4. stall: pc held (stall honoured in RUN only; ignored in FLUSH).
  5. otherwise: pc <= pc + 4.
- branch_taken is ignored unless branch_valid = 1.
- If jump_valid and branch_valid are both high, the jump wins and only one redirect is counted.
- A redirect overrides stall and halt in the same cycle.
- Redirect timing:
  - At the redirect edge, pc takes the target with its low two bits forced to 00.
  - If target[1:0] != 0, misaligned sets and stays set until reset.
  - state becomes FLUSH, flush goes to 1, flush counter loads FLUSH_CYCLES.
  - redirect_count increments, saturating at all-ones.
- FLUSH:
  - flush = 1 and pc_valid = 1; pc advances by 4 each cycle (wrong-path fetches are already squashed downstream).
  - The counter decrements each cycle. When it reaches 1, the next edge returns to RUN with flush = 0.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles.
  - A new redirect during FLUSH reloads the counter to FLUSH_CYCLES and retargets pc; flush stays high continuously.
- HALTED:
  - pc frozen, pc_valid = 0, flush = 0.
  - All inputs ignored; only rst exits.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Wrap-around: pc = 32'hFFFF_FFFC increments to 32'h0000_0000.

Test Plan:
- Reset/boot: assert rst mid-run with pc = 0x40, then release -> pc = 0x0 immediately; pc_valid = 0 for one cycle; then pc runs 0x0, 0x4, 0x8; flush = 0.
- Taken branch: pc = 0x20; branch_valid = 1, branch_taken = 1, branch_pc = 0x18, branch_offset = 0xFFFF_FFFE -> next pc = 0x14; flush high exactly 2 cycles; pc 0x18, 0x1C during flush; redirect_count = 1.
- Not taken, stall, and halt precedence:
  - branch_valid = 1, branch_taken = 0 -> pc + 4, no flush, count unchanged.
  - stall = 1 for 3 cycles in RUN -> pc constant.
  - stall together with a taken branch -> redirect happens.
- Jump vs branch collision and back-to-back redirects:
  - jump_valid = 1 (jump_target = 0x100) with a taken branch in the same cycle -> pc = 0x400, count +1 only.
  - A second jump one cycle later, during FLUSH -> pc retargets and flush stays high 2 more cycles (3 total).
- Misaligned target and saturation:
  - Jump with jump_target = 0x3FFF_FFFF -> pc = 0xFFFF_FFFC, misaligned = 1 (sticky). Then pc wraps to 0x0 after 0xFFFF_FFFC.
  - Force 70000 redirects with CNT_W = 16 -> redirect_count holds 0xFFFF.
- Halt: halt = 1 in RUN at pc = 0x30 -> pc stays 0x30, pc_valid = 0, later jumps ignored; rst -> back to BOOT.
